// File: rtl/vsm_pkg.sv
// Constants shared between the vector-scalar multiplier and its output drain,
// plus the lane-index width helper used to size lane counters.
package vsm_pkg;

    localparam int VSM_SIZE  = 6;
    localparam int VSM_WIDTH = 8;

    // A single-lane vector still needs a 1-bit index port.
    function automatic int lane_idx_w(input int size);
        return (size > 1) ? $clog2(size) : 1;
    endfunction

endpackage

// File: rtl/vec_pingpong.sv
// Two-entry result-vector buffer: writes land in the free entry, reads come
// from the oldest; occupancy EMPTY/ONE/FULL tracks how many entries are live.
module vec_pingpong
    import vsm_pkg::*;
#(
    parameter int SIZE  = VSM_SIZE,
    parameter int WIDTH = VSM_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [SIZE*WIDTH-1:0]   wr_dat,
    input  logic                    rd_done,
    output logic [SIZE*WIDTH-1:0]   rd_dat,
    output logic                    empty,
    output logic                    full
);

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_t;

    occ_t                  occ_q, occ_d;
    logic                  wr_ptr_q, wr_ptr_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic [SIZE*WIDTH-1:0] mem_q [2];
    logic [SIZE*WIDTH-1:0] mem_d [2];

    always_comb begin
        occ_d    = occ_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        for (int i = 0; i < 2; i++) begin
            mem_d[i] = mem_q[i];
            if (wr_en && (wr_ptr_q == 1'(i))) begin
                mem_d[i] = wr_dat;
            end
        end
        if (wr_en) begin
            wr_ptr_d = ~wr_ptr_q;
        end
        if (rd_done) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        // Simultaneous write and free leaves occupancy unchanged.
        case ({wr_en, rd_done})
            2'b10:   occ_d = (occ_q == OCC_EMPTY) ? OCC_ONE : OCC_FULL;
            2'b01:   occ_d = (occ_q == OCC_FULL)  ? OCC_ONE : OCC_EMPTY;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            occ_q    <= OCC_EMPTY;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            occ_q    <= occ_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            for (int i = 0; i < 2; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign rd_dat = mem_q[rd_ptr_q];
    assign empty  = (occ_q == OCC_EMPTY);
    assign full   = (occ_q == OCC_FULL);

endmodule

// File: rtl/vsm_drain.sv
// Multiplier output drain: buffers up to two result vectors and streams them one
// lane per valid/ready handshake; vec_ready depends only on registered occupancy.
module vsm_drain
    import vsm_pkg::*;
#(
    parameter int SIZE  = VSM_SIZE,
    parameter int WIDTH = VSM_WIDTH,
    parameter int IDX_W = lane_idx_w(SIZE)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  vec_valid,
    output logic                  vec_ready,
    input  logic [SIZE*WIDTH-1:0] vec_data,
    output logic                  lane_valid,
    input  logic                  lane_ready,
    output logic [WIDTH-1:0]      lane_data,
    output logic [IDX_W-1:0]      lane_idx,
    output logic                  lane_last,
    output logic                  overflow,
    output logic                  busy
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SIZE - 1);

    logic [SIZE*WIDTH-1:0] rd_dat;
    logic                  buf_empty;
    logic                  buf_full;
    logic                  vec_acc;
    logic                  lane_xfer;
    logic                  last_xfer;
    logic [IDX_W-1:0]      lane_cnt_q, lane_cnt_d;
    logic                  overflow_q, overflow_d;

    assign vec_acc   = vec_valid && vec_ready;
    assign lane_xfer = lane_valid && lane_ready;
    assign last_xfer = lane_xfer && (lane_cnt_q == LAST_IDX);

    vec_pingpong #(
        .SIZE  (SIZE),
        .WIDTH (WIDTH)
    ) u_pingpong (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (vec_acc),
        .wr_dat  (vec_data),
        .rd_done (last_xfer),
        .rd_dat  (rd_dat),
        .empty   (buf_empty),
        .full    (buf_full)
    );

    always_comb begin
        lane_cnt_d = lane_cnt_q;
        if (lane_xfer) begin
            lane_cnt_d = last_xfer ? '0 : lane_cnt_q + 1'b1;
        end
        // A dropped vector is only flagged; it never touches the buffer.
        overflow_d = overflow_q | (vec_valid && !vec_ready);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lane_cnt_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            lane_cnt_q <= lane_cnt_d;
            overflow_q <= overflow_d;
        end
    end

    // The oldest entry is never overwritten while it drains, so this mux holds
    // steady under backpressure without an output register.
    always_comb begin
        lane_data = '0;
        for (int i = 0; i < SIZE; i++) begin
            if (lane_cnt_q == IDX_W'(i)) begin
                lane_data = rd_dat[WIDTH*i +: WIDTH];
            end
        end
    end

    assign vec_ready  = !buf_full;
    assign busy       = !buf_empty;
    assign lane_valid = !buf_empty;
    assign lane_idx   = lane_cnt_q;
    assign lane_last  = lane_valid && (lane_cnt_q == LAST_IDX);
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_vsm_drain.sv
// Scoreboard bench for vsm_drain: directed test-plan scenarios then random traffic,
// checked against a lane-queue reference model.
module tb_vsm_drain;

    localparam int SIZE  = 6;
    localparam int WIDTH = 8;
    localparam int IDX_W = 3;

    logic                  clk;
    logic                  reset;
    logic                  vec_valid;
    logic                  vec_ready;
    logic [SIZE*WIDTH-1:0] vec_data;
    logic                  lane_valid;
    logic                  lane_ready;
    logic [WIDTH-1:0]      lane_data;
    logic [IDX_W-1:0]      lane_idx;
    logic                  lane_last;
    logic                  overflow;
    logic                  busy;

    vsm_drain #(.SIZE(SIZE), .WIDTH(WIDTH), .IDX_W(IDX_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .vec_valid  (vec_valid),
        .vec_ready  (vec_ready),
        .vec_data   (vec_data),
        .lane_valid (lane_valid),
        .lane_ready (lane_ready),
        .lane_data  (lane_data),
        .lane_idx   (lane_idx),
        .lane_last  (lane_last),
        .overflow   (overflow),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] d;
        int               idx;
    } lane_t;

    lane_t                 exp_q[$];
    logic                  exp_ovf;
    logic                  mdl_rdy;
    logic                  cur_vv;
    logic [SIZE*WIDTH-1:0] cur_vd;
    int                    checks;
    int                    errors;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the drain is a FIFO of lanes; a vector occupies a slot
    // until its last lane leaves, and at most two vectors fit.
    always @(negedge clk) begin
        int nvec;
        if (!reset) begin
            chk("rst_lane_valid", 64'(lane_valid), 64'(0));
            chk("rst_lane_data",  64'(lane_data),  64'(0));
            chk("rst_lane_idx",   64'(lane_idx),   64'(0));
            chk("rst_lane_last",  64'(lane_last),  64'(0));
            chk("rst_overflow",   64'(overflow),   64'(0));
            chk("rst_busy",       64'(busy),       64'(0));
            chk("rst_vec_ready",  64'(vec_ready),  64'(1));
            mdl_rdy = 1'b1;
        end else begin
            nvec = (exp_q.size() + SIZE - 1) / SIZE;
            chk("vec_ready",  64'(vec_ready),  64'(nvec < 2));
            chk("busy",       64'(busy),       64'(nvec != 0));
            chk("overflow",   64'(overflow),   64'(exp_ovf));
            chk("lane_valid", 64'(lane_valid), 64'(exp_q.size() != 0));
            if (lane_valid && exp_q.size() != 0) begin
                chk("lane_data", 64'(lane_data), 64'(exp_q[0].d));
                chk("lane_idx",  64'(lane_idx),  64'(exp_q[0].idx));
                chk("lane_last", 64'(lane_last), 64'(exp_q[0].idx == SIZE - 1));
                if (lane_ready) begin
                    void'(exp_q.pop_front());
                end
            end
            mdl_rdy = (nvec < 2);
        end
    end

    // One cycle of stimulus; first books the outcome of the vector offered last cycle.
    task automatic step(input logic vv, input logic [SIZE*WIDTH-1:0] vd, input logic lr);
        @(posedge clk);
        #1;
        if (reset && cur_vv) begin
            if (mdl_rdy) begin
                for (int i = 0; i < SIZE; i++) begin
                    exp_q.push_back('{cur_vd[WIDTH*i +: WIDTH], i});
                end
            end else begin
                exp_ovf = 1'b1;
            end
        end
        vec_valid  = vv;
        vec_data   = vd;
        lane_ready = lr;
        cur_vv     = vv;
        cur_vd     = vd;
    endtask

    task automatic idle(input int n, input logic lr);
        for (int i = 0; i < n; i++) step(1'b0, '0, lr);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 100) begin
            step(1'b0, '0, 1'b1);
            guard++;
        end
        chk("drain_done", 64'(exp_q.size()), 64'(0));
        idle(2, 1'b1);
    endtask

    localparam logic [SIZE*WIDTH-1:0] V1 = 48'h060504030201;
    localparam logic [SIZE*WIDTH-1:0] V2 = 48'h0C0B0A090807;
    localparam logic [SIZE*WIDTH-1:0] V3 = 48'h1211100F0E0D;

    initial begin
        checks     = 0;
        errors     = 0;
        exp_ovf    = 1'b0;
        mdl_rdy    = 1'b1;
        cur_vv     = 1'b0;
        cur_vd     = '0;
        reset      = 1'b0;
        vec_valid  = 1'b0;
        vec_data   = '0;
        lane_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        // Single vector, full-rate drain.
        step(1'b1, V1, 1'b1);
        drain();

        // Two back-to-back vectors: twelve contiguous lanes.
        step(1'b1, V1, 1'b1);
        step(1'b1, V2, 1'b1);
        drain();

        // Backpressure at lane 2 for three cycles.
        step(1'b1, V1, 1'b1);
        idle(2, 1'b1);
        idle(3, 1'b0);
        drain();

        // Accept coinciding with last-lane transfer from ONE.
        step(1'b1, V1, 1'b1);
        idle(5, 1'b1);
        step(1'b1, V2, 1'b1);
        drain();

        // Fill, then offer a third vector while FULL.
        step(1'b1, V1, 1'b0);
        step(1'b1, V2, 1'b0);
        step(1'b1, V3, 1'b0);
        idle(2, 1'b0);
        drain();

        // Reset in the middle of a vector, at lane 3.
        step(1'b1, V1, 1'b1);
        idle(3, 1'b1);
        @(posedge clk);
        #3 reset = 1'b0;
        #1 chk("rst_async_drop", 64'(lane_valid), 64'(0));
        exp_q.delete();
        exp_ovf   = 1'b0;
        vec_valid = 1'b0;
        cur_vv    = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        step(1'b1, V2, 1'b1);
        drain();

        // Random traffic with varied offer and backpressure rates.
        for (int i = 0; i < 1500; i++) begin
            logic [SIZE*WIDTH-1:0] vd;
            int ph;
            ph = i / 500;
            vd = {16'($urandom), $urandom};
            step($urandom_range(0, 3) <= ph, vd, $urandom_range(0, 3) >= ph);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
